// File: rtl/dmux_sync_pkg.sv
// -----------------------------------------------------------------------------
// dmux_sync_pkg
// Shared definitions for the toggle-based data mux synchronizer pair
// (dmux_sync_tx on the source side, its receiver on the destination side).
//   sync_state_e  : two-state handshake FSM encoding (IDLE, BUSY)
//   DEFAULT_DEPTH : default number of synchronizer flops on a crossing toggle
// -----------------------------------------------------------------------------
package dmux_sync_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sync_state_e;

  localparam int unsigned DEFAULT_DEPTH = 2;

endpackage : dmux_sync_pkg

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// DEPTH-stage single-bit synchronizer for a level/toggle signal arriving from
// an unrelated clock domain.
// Ports:
//   clk   in  1  destination clock
//   rst_n in  1  asynchronous active-low reset, clears every stage to 0
//   d     in  1  asynchronous input
//   q     out 1  synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_ff
  import dmux_sync_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;

  // NOTE: every stage is reset, not just the output one; an unreset stage
  // would shift an X (or a stale toggle) out after reset and fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d};
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule : sync_ff

// File: rtl/dmux_sync_tx.sv
// -----------------------------------------------------------------------------
// dmux_sync_tx
// Source side of the toggle-based data mux synchronizer. A word accepted on a
// valid/ready handshake is registered onto tx_data and announced by flipping
// tx_toggle. No new word is accepted until the transfer is complete:
//   DMUX_SYNC_TX_ACK_EN defined   : wait until the destination's echoed toggle
//                                   (ack_toggle, synchronized) equals tx_toggle
//   DMUX_SYNC_TX_ACK_EN undefined : wait a fixed HOLD_CYCLES source cycles;
//                                   ack_toggle is then ignored
// Ports:
//   src_clk    in  1      source clock
//   src_rst_n  in  1      asynchronous active-low reset
//   src_valid  in  1      word offered on src_data
//   src_ready  out 1      block can accept a word (registered)
//   src_data   in  WIDTH  word to transfer
//   tx_toggle  out 1      request toggle to the receiver (registered)
//   tx_data    out WIDTH  held word to the receiver (registered)
//   ack_toggle in  1      echoed receiver toggle, asynchronous to src_clk
// -----------------------------------------------------------------------------
module dmux_sync_tx
  import dmux_sync_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned WIDTH       = 8,
  parameter logic        RST_VAL     = 1'b0,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic             tx_toggle,
  output logic [WIDTH-1:0] tx_data,
  input  logic             ack_toggle
);

  sync_state_e      state_q, state_d;
  logic             ready_q;
  logic             toggle_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;
  logic             leave_busy;

  // ready_q mirrors state_q == IDLE, so it alone qualifies the handshake.
  assign accept = src_valid && ready_q;

`ifdef DMUX_SYNC_TX_ACK_EN
  localparam int unsigned unused_hold = HOLD_CYCLES;

  logic ack_sync;

  sync_ff #(
    .DEPTH (DEPTH)
  ) u_ack_sync (
    .clk   (src_clk),
    .rst_n (src_rst_n),
    .d     (ack_toggle),
    .q     (ack_sync)
  );

  // Equality only: the direction of the echoed edge carries no information.
  assign leave_busy = (ack_sync == toggle_q);
`else
  localparam int unsigned            unused_depth = DEPTH;
  localparam int unsigned            CNT_W        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]       HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE      = CNT_W'(1);

  logic             unused_ack;
  logic [CNT_W-1:0] hold_cnt_q;

  assign unused_ack = ack_toggle;

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      hold_cnt_q <= '0;
    end else if (accept) begin
      hold_cnt_q <= HOLD_LOAD;
    end else if (state_q == BUSY && hold_cnt_q != '0) begin
      hold_cnt_q <= hold_cnt_q - CNT_ONE;
    end
  end

  // Leave on the edge where the counter reaches 0 so that, with ready
  // registered, the next accept lands exactly HOLD_CYCLES edges after the
  // previous one. A zero load (HOLD_CYCLES == 1) leaves on the first busy edge.
  assign leave_busy = (hold_cnt_q <= CNT_ONE);
`endif

  // NOTE: state_d gets its default before the case so that no path through
  // this block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)     state_d = BUSY;
      BUSY:    if (leave_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      toggle_q <= 1'b0;
      data_q   <= {WIDTH{RST_VAL}};
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      if (accept) begin
        data_q   <= src_data;
        toggle_q <= ~toggle_q;
      end
    end
  end

  assign src_ready = ready_q;
  assign tx_toggle = toggle_q;
  assign tx_data   = data_q;

endmodule : dmux_sync_tx
